// File: rtl/tb_mem_scheduler_if.sv
// Port bundle for the traceback direction memory scheduler: writer, reader, status and SRAM port.
// o_rd_err exists only when TBM_RD_GUARD_EN is defined.
interface tb_mem_scheduler_if #(
  parameter int N_BANK = 16,
  parameter int DEPTH  = 512,
  parameter int DW     = 64
);
  localparam int BW = $clog2(N_BANK);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(N_BANK * DEPTH) + 1;

  logic          i_clear;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [DW-1:0] i_wr_v_0, i_wr_v_1, i_wr_i, i_wr_d;

  logic          i_rd_valid;
  logic [BW-1:0] i_rd_bank;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_ready;
  logic          o_rd_dvalid;
`ifdef TBM_RD_GUARD_EN
  logic          o_rd_err;
`endif
  logic [DW-1:0] o_rd_v_0, o_rd_v_1, o_rd_i, o_rd_d;

  logic [CW-1:0] o_wr_count;
  logic          o_full;

  logic          o_cen, o_wen;
  logic [BW-1:0] o_bank;
  logic [AW-1:0] o_address;
  logic [DW-1:0] o_v_0, o_v_1, o_i, o_d;
  logic [DW-1:0] i_q_v_0, i_q_v_1, i_q_i, i_q_d;

  modport slave (
    input  i_clear, i_wr_valid, i_wr_v_0, i_wr_v_1, i_wr_i, i_wr_d,
           i_rd_valid, i_rd_bank, i_rd_addr,
           i_q_v_0, i_q_v_1, i_q_i, i_q_d,
    output o_wr_ready, o_rd_ready, o_rd_dvalid,
`ifdef TBM_RD_GUARD_EN
           o_rd_err,
`endif
           o_rd_v_0, o_rd_v_1, o_rd_i, o_rd_d,
           o_wr_count, o_full,
           o_cen, o_wen, o_bank, o_address, o_v_0, o_v_1, o_i, o_d
  );

  modport master (
    output i_clear, i_wr_valid, i_wr_v_0, i_wr_v_1, i_wr_i, i_wr_d,
           i_rd_valid, i_rd_bank, i_rd_addr,
           i_q_v_0, i_q_v_1, i_q_i, i_q_d,
    input  o_wr_ready, o_rd_ready, o_rd_dvalid,
`ifdef TBM_RD_GUARD_EN
           o_rd_err,
`endif
           o_rd_v_0, o_rd_v_1, o_rd_i, o_rd_d,
           o_wr_count, o_full,
           o_cen, o_wen, o_bank, o_address, o_v_0, o_v_1, o_i, o_d
  );
endinterface

// File: rtl/tb_mem_scheduler.sv
// Arbiter/sequencer sharing the single-port banked direction memory between a streaming writer
// and a random reader. Define TBM_RD_GUARD_EN to suppress reads beyond the write pointer.
module tb_mem_scheduler #(
  parameter int N_BANK   = 16,
  parameter int DEPTH    = 512,
  parameter int DW       = 64,
  parameter int WR_BURST = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  tb_mem_scheduler_if.slave bus
);
  localparam int BW = $clog2(N_BANK);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = BW + AW;
  localparam int CW = LW + 1;
  localparam int SW = $clog2(WR_BURST + 1);
  localparam logic [CW-1:0] TOTAL = CW'(N_BANK * DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wr_count;
  logic [SW-1:0] streak;
  logic          wr_can, rd_can, wr_grant, rd_grant, rd_oob;
  // issue_now: memory is being read this cycle; cap_now: read data is on i_q_* this cycle
  logic          issue_now, cap_now, issue_err, cap_err;
  logic          rd_dvalid;
  logic [DW-1:0] rd_v_0, rd_v_1, rd_i, rd_d;
  logic          cen, wen;
  logic [BW-1:0] bank;
  logic [AW-1:0] address;
  logic [DW-1:0] v_0, v_1, v_i, v_d;

`ifdef TBM_RD_GUARD_EN
  assign rd_oob = CW'({bus.i_rd_bank, bus.i_rd_addr}) >= wr_count;
`else
  assign rd_oob = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_can   = bus.i_wr_valid && (state != FULL) && !bus.i_clear && !issue_now;
    rd_can   = bus.i_rd_valid && !issue_now;
    wr_grant = wr_can && !(rd_can && (streak >= SW'(WR_BURST)));
    rd_grant = rd_can && !wr_grant;
  end

  always_comb begin
    state_nx = state;
    if (bus.i_clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (wr_grant) state_nx = FILL;
        FILL:    if (wr_grant && (wr_count == TOTAL - CW'(1))) state_nx = FULL;
        FULL:    state_nx = FULL;
        default: state_nx = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      wr_count <= '0;
      streak   <= '0;
    end else begin
      state <= state_nx;
      if (bus.i_clear)   wr_count <= '0;
      else if (wr_grant) wr_count <= wr_count + CW'(1);
      // Streak only measures how long a waiting read has been starved
      if (!bus.i_rd_valid || rd_grant)                  streak <= '0;
      else if (wr_grant && (streak < SW'(WR_BURST)))    streak <= streak + SW'(1);
    end
  end

  // Read pipeline: grant -> issue -> capture -> dvalid
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      issue_now <= 1'b0;
      issue_err <= 1'b0;
      cap_now   <= 1'b0;
      cap_err   <= 1'b0;
      rd_dvalid <= 1'b0;
      rd_v_0    <= '0;
      rd_v_1    <= '0;
      rd_i      <= '0;
      rd_d      <= '0;
    end else begin
      issue_now <= rd_grant;
      issue_err <= rd_grant && rd_oob;
      cap_now   <= issue_now;
      cap_err   <= issue_err;
      rd_dvalid <= cap_now;
      if (cap_now) begin
        if (cap_err) begin
          rd_v_0 <= '0;
          rd_v_1 <= '0;
          rd_i   <= '0;
          rd_d   <= '0;
        end else begin
          rd_v_0 <= bus.i_q_v_0;
          rd_v_1 <= bus.i_q_v_1;
          rd_i   <= bus.i_q_i;
          rd_d   <= bus.i_q_d;
        end
      end
    end
  end

`ifdef TBM_RD_GUARD_EN
  logic rd_err;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rd_err <= 1'b0;
    else       rd_err <= cap_now && cap_err;
  end
  assign bus.o_rd_err = rd_err;
`endif

  // Memory port register: idle cycles deselect but hold address and data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cen     <= 1'b1;
      wen     <= 1'b1;
      bank    <= '0;
      address <= '0;
      v_0     <= '0;
      v_1     <= '0;
      v_i     <= '0;
      v_d     <= '0;
    end else if (wr_grant) begin
      cen     <= 1'b0;
      wen     <= 1'b0;
      bank    <= wr_count[LW-1:AW];
      address <= wr_count[AW-1:0];
      v_0     <= bus.i_wr_v_0;
      v_1     <= bus.i_wr_v_1;
      v_i     <= bus.i_wr_i;
      v_d     <= bus.i_wr_d;
    end else if (rd_grant && !rd_oob) begin
      cen     <= 1'b0;
      wen     <= 1'b1;
      bank    <= bus.i_rd_bank;
      address <= bus.i_rd_addr;
    end else begin
      cen <= 1'b1;
      wen <= 1'b1;
    end
  end

  assign bus.o_wr_ready  = wr_grant;
  assign bus.o_rd_ready  = rd_grant;
  assign bus.o_rd_dvalid = rd_dvalid;
  assign bus.o_rd_v_0    = rd_v_0;
  assign bus.o_rd_v_1    = rd_v_1;
  assign bus.o_rd_i      = rd_i;
  assign bus.o_rd_d      = rd_d;
  assign bus.o_wr_count  = wr_count;
  assign bus.o_full      = (wr_count == TOTAL);
  assign bus.o_cen       = cen;
  assign bus.o_wen       = wen;
  assign bus.o_bank      = bank;
  assign bus.o_address   = address;
  assign bus.o_v_0       = v_0;
  assign bus.o_v_1       = v_1;
  assign bus.o_i         = v_i;
  assign bus.o_d         = v_d;
endmodule
